// File: rtl/bp_cce_hybrid_uc_xlate_pkg.sv
// Shared types for the hybrid CCE uncached translator: the BedRock header
// layouts it uses, its FSM states and the request-to-command type mapping.
package bp_me_pkg;

  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 4;
  localparam int cce_id_width_gp = 4;
  localparam int way_id_width_gp = 3;
  localparam int dword_width_gp  = 64;

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3,
    e_bedrock_req_uc_amo  = 4'd4
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  // Cache block is 64 bytes; misses served uncached fetch a whole block.
  localparam bp_bedrock_msg_size_e block_size_gp = e_bedrock_msg_size_64;

  typedef struct packed {
    logic                       non_exclusive;
    logic [way_id_width_gp-1:0] lru_way_id;
    logic [cce_id_width_gp-1:0] dst_id;
    logic [lce_id_width_gp-1:0] src_id;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_lce_req_payload_s payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_req_type_e        msg_type;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    logic                       uncached;
    logic [2:0]                 state;
    logic [way_id_width_gp-1:0] way_id;
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_mem_fwd_payload_s;

  typedef struct packed {
    bp_bedrock_mem_fwd_payload_s payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_fwd_header_s;

  localparam int lce_req_msg_header_width_gp = $bits(bp_bedrock_lce_req_header_s);
  localparam int mem_fwd_header_width_gp     = $bits(bp_bedrock_mem_fwd_header_s);

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_ready = 2'd1,
    e_data  = 2'd2
  } bp_cce_hybrid_uc_xlate_state_e;

  // Only writes stay writes; every other request becomes an uncached read.
  function automatic bp_bedrock_mem_type_e bp_me_uc_mem_type(bp_bedrock_req_type_e req_type);
    return (req_type == e_bedrock_req_uc_wr) ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
  endfunction

  function automatic logic bp_me_uc_type_known(bp_bedrock_req_type_e req_type);
    return (req_type == e_bedrock_req_rd_miss) || (req_type == e_bedrock_req_wr_miss)
        || (req_type == e_bedrock_req_uc_rd)   || (req_type == e_bedrock_req_uc_wr);
  endfunction

endpackage

// File: rtl/bp_cce_hybrid_uc_xlate_counter.sv
// Saturating up/down counter used to track memory command credits.
module bsg_counter_up_down #(
  parameter int max_val_p    = 4,
  parameter int init_val_p   = 4,
  parameter int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    up_i,
  input  logic                    down_i,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam logic [ptr_width_lp-1:0] max_lp  = ptr_width_lp'(max_val_p);
  localparam logic [ptr_width_lp-1:0] init_lp = ptr_width_lp'(init_val_p);

  logic [ptr_width_lp-1:0] count_q, count_d;

  // Next count: simultaneous up and down cancel; both ends saturate.
  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = (count_q == max_lp) ? count_q : count_q + 1'b1;
    end else if (down_i && !up_i) begin
      count_d = (count_q == '0) ? count_q : count_q - 1'b1;
    end
  end

  // Count register, loaded with the initial value during reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= init_lp;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_hybrid_uc_xlate.sv
// Converts uncached LCE request bursts into BedRock memory command bursts
// with zero latency, bounding outstanding commands with a credit counter.
module bp_cce_hybrid_uc_xlate
  import bp_me_pkg::*;
#(
  parameter int lce_data_width_p = dword_width_gp,
  parameter int mem_credits_p    = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   stall_i,
  output logic                                   empty_o,
  input  logic [lce_req_msg_header_width_gp-1:0] lce_req_header_i,
  input  logic                                   lce_req_header_v_i,
  output logic                                   lce_req_header_ready_and_o,
  input  logic                                   lce_req_has_data_i,
  input  logic [lce_data_width_p-1:0]            lce_req_data_i,
  input  logic                                   lce_req_data_v_i,
  output logic                                   lce_req_data_ready_and_o,
  input  logic                                   lce_req_last_i,
  output logic [mem_fwd_header_width_gp-1:0]     mem_cmd_header_o,
  output logic                                   mem_cmd_header_v_o,
  input  logic                                   mem_cmd_header_ready_and_i,
  output logic                                   mem_cmd_has_data_o,
  output logic [lce_data_width_p-1:0]            mem_cmd_data_o,
  output logic                                   mem_cmd_data_v_o,
  input  logic                                   mem_cmd_data_ready_and_i,
  output logic                                   mem_cmd_last_o,
  input  logic                                   mem_credit_return_i
);

  localparam int credit_width_lp = $clog2(mem_credits_p + 1);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(mem_credits_p);

  bp_cce_hybrid_uc_xlate_state_e state_q, state_d;
  bp_bedrock_lce_req_header_s    req_hdr;
  bp_bedrock_mem_fwd_header_s    cmd_hdr;
  logic [credit_width_lp-1:0]    credits;
  logic                          credit_avail;
  logic                          hdr_fire;

  assign req_hdr      = bp_bedrock_lce_req_header_s'(lce_req_header_i);
  assign credit_avail = (credits != '0);

  // Header field translation; misses are served as block-sized uncached reads.
  always_comb begin
    cmd_hdr                  = '0;
    cmd_hdr.msg_type         = bp_me_uc_mem_type(req_hdr.msg_type);
    cmd_hdr.addr             = req_hdr.addr;
    cmd_hdr.size             = req_hdr.size;
    cmd_hdr.payload.lce_id   = req_hdr.payload.src_id;
    cmd_hdr.payload.uncached = 1'b1;
    if ((req_hdr.msg_type == e_bedrock_req_rd_miss) || (req_hdr.msg_type == e_bedrock_req_wr_miss)) begin
      cmd_hdr.size = block_size_gp;
    end
  end

  assign mem_cmd_header_o   = cmd_hdr;
  assign mem_cmd_has_data_o = lce_req_has_data_i;
  assign mem_cmd_data_o     = lce_req_data_i;
  assign mem_cmd_last_o     = lce_req_last_i;

  // Next-state and handshake gating; headers and beats never share a cycle.
  always_comb begin
    state_d                    = state_q;
    mem_cmd_header_v_o         = 1'b0;
    lce_req_header_ready_and_o = 1'b0;
    mem_cmd_data_v_o           = 1'b0;
    lce_req_data_ready_and_o   = 1'b0;
    hdr_fire                   = 1'b0;
    unique case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        mem_cmd_header_v_o         = lce_req_header_v_i & ~stall_i & credit_avail;
        lce_req_header_ready_and_o = mem_cmd_header_ready_and_i & ~stall_i & credit_avail;
        hdr_fire                   = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
        if (hdr_fire && lce_req_has_data_i) state_d = e_data;
      end
      e_data: begin
        mem_cmd_data_v_o         = lce_req_data_v_i;
        lce_req_data_ready_and_o = mem_cmd_data_ready_and_i;
        if (lce_req_data_v_i && mem_cmd_data_ready_and_i && lce_req_last_i) state_d = e_ready;
      end
      default: state_d = e_reset;
    endcase
  end

  // State register; held in e_reset for as long as reset is asserted.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_reset;
    else         state_q <= state_d;
  end

  bsg_counter_up_down #(
    .max_val_p (mem_credits_p),
    .init_val_p(mem_credits_p)
  ) credit_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (mem_credit_return_i),
    .down_i (hdr_fire),
    .count_o(credits)
  );

  assign empty_o = (state_q == e_ready) && (credits == max_credits_lp);

`ifndef SYNTHESIS
  // Flag unsupported request types and credit returns with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(hdr_fire && !bp_me_uc_type_known(req_hdr.msg_type)))
        else $error("uc_xlate: unsupported request type %0d", req_hdr.msg_type);
      assert (!(mem_credit_return_i && (credits == max_credits_lp)))
        else $error("uc_xlate: credit return with all credits present");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_uc_xlate.sv
// Bench for the uncached translator: cycle-by-cycle behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_bp_cce_hybrid_uc_xlate;
  import bp_me_pkg::*;

  localparam int CRED = 4;
  localparam int DW   = 64;
  localparam int HW   = lce_req_msg_header_width_gp;
  localparam int MW   = mem_fwd_header_width_gp;

  logic          clk = 1'b0;
  logic          reset_i, stall_i, empty_o;
  logic [HW-1:0] lce_req_header_i;
  logic          lce_req_header_v_i, lce_req_header_ready_and_o, lce_req_has_data_i;
  logic [DW-1:0] lce_req_data_i;
  logic          lce_req_data_v_i, lce_req_data_ready_and_o, lce_req_last_i;
  logic [MW-1:0] mem_cmd_header_o;
  logic          mem_cmd_header_v_o, mem_cmd_header_ready_and_i, mem_cmd_has_data_o;
  logic [DW-1:0] mem_cmd_data_o;
  logic          mem_cmd_data_v_o, mem_cmd_data_ready_and_i, mem_cmd_last_o;
  logic          mem_credit_return_i;

  bp_cce_hybrid_uc_xlate #(.lce_data_width_p(DW), .mem_credits_p(CRED)) dut (
    .clk_i(clk), .reset_i(reset_i), .stall_i(stall_i), .empty_o(empty_o),
    .lce_req_header_i(lce_req_header_i), .lce_req_header_v_i(lce_req_header_v_i),
    .lce_req_header_ready_and_o(lce_req_header_ready_and_o), .lce_req_has_data_i(lce_req_has_data_i),
    .lce_req_data_i(lce_req_data_i), .lce_req_data_v_i(lce_req_data_v_i),
    .lce_req_data_ready_and_o(lce_req_data_ready_and_o), .lce_req_last_i(lce_req_last_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
    .mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i), .mem_cmd_has_data_o(mem_cmd_has_data_o),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i), .mem_cmd_last_o(mem_cmd_last_o),
    .mem_credit_return_i(mem_credit_return_i)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: whether the block is still coming out of reset, whether a
  // data burst is open, and how many memory commands are outstanding.
  bit m_rst   = 1'b1;
  bit m_burst = 1'b0;
  int m_out   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [MW-1:0] model_cmd(input logic [HW-1:0] raw);
    bp_bedrock_lce_req_header_s r;
    bp_bedrock_mem_fwd_header_s c;
    bit miss;
    r = bp_bedrock_lce_req_header_s'(raw);
    c = '0;
    miss = (r.msg_type == e_bedrock_req_rd_miss) || (r.msg_type == e_bedrock_req_wr_miss);
    c.msg_type = (r.msg_type == e_bedrock_req_uc_wr) ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    c.addr = r.addr;
    c.size = miss ? e_bedrock_msg_size_64 : r.size;
    c.payload.lce_id = r.payload.src_id;
    c.payload.uncached = 1'b1;
    return c;
  endfunction

  // Per-cycle compare against the model, then advance the model at the edge.
  initial begin
    bit up, can, e_hv, e_hr, e_dv, e_dr, e_empty, hfire, dfire, ret, lastb, hasd, rsts;
    @(posedge clk);
    forever begin
      @(negedge clk);
      up      = !m_rst;
      can     = up && !m_burst && !stall_i && (m_out < CRED);
      e_hv    = can && lce_req_header_v_i;
      e_hr    = can && mem_cmd_header_ready_and_i;
      e_dv    = up && m_burst && lce_req_data_v_i;
      e_dr    = up && m_burst && mem_cmd_data_ready_and_i;
      e_empty = up && !m_burst && (m_out == 0);
      chk("hdr_v", mem_cmd_header_v_o, e_hv);
      chk("hdr_ready", lce_req_header_ready_and_o, e_hr);
      chk("data_v", mem_cmd_data_v_o, e_dv);
      chk("data_ready", lce_req_data_ready_and_o, e_dr);
      chk("empty", empty_o, e_empty);
      if (e_hv) begin
        chk("hdr", mem_cmd_header_o, model_cmd(lce_req_header_i));
        chk("has_data", mem_cmd_has_data_o, lce_req_has_data_i);
      end
      if (e_dv) begin
        chk("data", mem_cmd_data_o, lce_req_data_i);
        chk("last", mem_cmd_last_o, lce_req_last_i);
      end
      hfire = e_hv && e_hr;
      dfire = e_dv && e_dr;
      ret   = mem_credit_return_i;
      lastb = lce_req_last_i;
      hasd  = lce_req_has_data_i;
      rsts  = reset_i;
      @(posedge clk);
      if (rsts) begin
        m_rst = 1'b1; m_out = 0; m_burst = 1'b0;
      end else if (m_rst) begin
        m_rst = 1'b0;
      end else begin
        m_out = m_out + int'(hfire) - int'(ret);
        if (m_out < 0) m_out = 0;
        if (hfire && hasd) m_burst = 1'b1;
        if (dfire && lastb) m_burst = 1'b0;
      end
    end
  end

  task automatic set_hdr(input bp_bedrock_req_type_e t, input logic [39:0] a,
                         input bp_bedrock_msg_size_e s, input logic [3:0] src, input logic hd);
    bp_bedrock_lce_req_header_s h;
    h = '0;
    h.msg_type = t; h.addr = a; h.size = s; h.payload.src_id = src; h.payload.dst_id = 4'h0;
    lce_req_header_i   = h;
    lce_req_has_data_i = hd;
  endtask

  task automatic send_hdr(output int fire_cyc, output logic [MW-1:0] cap);
    bit done = 1'b0;
    int n = 0;
    fire_cyc = -1; cap = '0;
    lce_req_header_v_i = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      if (lce_req_header_ready_and_o) begin
        done = 1'b1; cap = mem_cmd_header_o; fire_cyc = cyc;
      end
      @(posedge clk); #1;
      n++;
    end
    lce_req_header_v_i = 1'b0;
    n_total++;
    if (done) n_pass++;
    else $display("FAIL hdr_timeout: got no handshake expected one within 40 cycles");
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, output int fire_cyc,
                           output logic [DW-1:0] cap_d, output logic cap_l);
    bit done = 1'b0;
    int n = 0;
    fire_cyc = -1; cap_d = '0; cap_l = 1'b0;
    lce_req_data_i = d; lce_req_last_i = l; lce_req_data_v_i = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      if (lce_req_data_ready_and_o) begin
        done = 1'b1; cap_d = mem_cmd_data_o; cap_l = mem_cmd_last_o; fire_cyc = cyc;
      end
      @(posedge clk); #1;
      n++;
    end
    lce_req_data_v_i = 1'b0; lce_req_last_i = 1'b0;
    n_total++;
    if (done) n_pass++;
    else $display("FAIL beat_timeout: got no handshake expected one within 40 cycles");
  endtask

  task automatic credit_pulse();
    mem_credit_return_i = 1'b1;
    @(posedge clk); #1;
    mem_credit_return_i = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    int hc, dc, dc2;
    logic [MW-1:0] cap;
    logic [DW-1:0] capd;
    logic capl;
    bp_bedrock_mem_fwd_header_s ec, gc;

    reset_i = 1'b1; stall_i = 1'b0; lce_req_header_i = '0; lce_req_header_v_i = 1'b0;
    lce_req_has_data_i = 1'b0; lce_req_data_i = '0; lce_req_data_v_i = 1'b0; lce_req_last_i = 1'b0;
    mem_cmd_header_ready_and_i = 1'b1; mem_cmd_data_ready_and_i = 1'b1; mem_credit_return_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty_o, 1'b0);
    chk("rst_hdr_ready", lce_req_header_ready_and_o, 1'b0);
    chk("rst_data_ready", lce_req_data_ready_and_o, 1'b0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_empty", empty_o, 1'b1);

    // Single uncached read.
    set_hdr(e_bedrock_req_uc_rd, 40'h80000040, e_bedrock_msg_size_8, 4'h1, 1'b0);
    send_hdr(hc, cap);
    ec = '0; ec.msg_type = e_bedrock_mem_uc_rd; ec.addr = 40'h80000040;
    ec.size = e_bedrock_msg_size_8; ec.payload.lce_id = 4'h1; ec.payload.uncached = 1'b1;
    chk("uc_rd_cmd", cap, ec);
    chk("uc_rd_model_out", m_out, 1);
    chk("uc_rd_empty", empty_o, 1'b0);
    credit_pulse();
    chk("uc_rd_empty_ret", empty_o, 1'b1);

    // Uncached write, one beat offered together with the header.
    set_hdr(e_bedrock_req_uc_wr, 40'h80001000, e_bedrock_msg_size_4, 4'h2, 1'b1);
    lce_req_data_i = 64'hDEAD_BEEF; lce_req_last_i = 1'b1; lce_req_data_v_i = 1'b1;
    send_hdr(hc, cap);
    gc = bp_bedrock_mem_fwd_header_s'(cap);
    chk("uc_wr_type", gc.msg_type, 4'd3);
    send_beat(64'hDEAD_BEEF, 1'b1, dc, capd, capl);
    chk("uc_wr_gap", dc > hc, 1'b1);
    chk("uc_wr_data", capd, 64'hDEAD_BEEF);
    chk("uc_wr_last", capl, 1'b1);
    lce_req_has_data_i = 1'b0;
    #1;
    chk("uc_wr_back_ready", lce_req_header_ready_and_o, 1'b1);
    credit_pulse();

    // Five reads, no returns: the fifth waits for a credit.
    for (int i = 0; i < 4; i++) begin
      set_hdr(e_bedrock_req_uc_rd, 40'h80000000 + 40'(i * 64), e_bedrock_msg_size_8, 4'h1, 1'b0);
      send_hdr(hc, cap);
    end
    chk("five_model_out", m_out, 4);
    set_hdr(e_bedrock_req_uc_rd, 40'h80000100, e_bedrock_msg_size_8, 4'h1, 1'b0);
    lce_req_header_v_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("five_held", lce_req_header_ready_and_o, 1'b0);
    end
    @(posedge clk); #1;
    mem_credit_return_i = 1'b1;
    @(negedge clk);
    chk("five_held_ret", lce_req_header_ready_and_o, 1'b0);
    @(posedge clk); #1;
    mem_credit_return_i = 1'b0;
    @(negedge clk);
    chk("five_release", lce_req_header_ready_and_o, 1'b1);
    @(posedge clk); #1;
    lce_req_header_v_i = 1'b0;
    chk("five_model_out2", m_out, 4);
    credit_pulse();
    credit_pulse();

    // Send and return in the same cycle: count stays at 2.
    set_hdr(e_bedrock_req_uc_rd, 40'h80000200, e_bedrock_msg_size_8, 4'h1, 1'b0);
    mem_credit_return_i = 1'b1;
    send_hdr(hc, cap);
    mem_credit_return_i = 1'b0;
    chk("same_cyc_model_out", m_out, 2);
    credit_pulse();
    chk("same_cyc_not_empty", empty_o, 1'b0);
    credit_pulse();
    chk("same_cyc_empty", empty_o, 1'b1);

    // Read miss becomes a block-sized uncached read.
    set_hdr(e_bedrock_req_rd_miss, 40'h80002000, e_bedrock_msg_size_8, 4'h3, 1'b0);
    send_hdr(hc, cap);
    gc = bp_bedrock_mem_fwd_header_s'(cap);
    chk("miss_type", gc.msg_type, 4'd2);
    chk("miss_size", gc.size, 3'd6);
    chk("miss_uncached", gc.payload.uncached, 1'b1);
    chk("miss_lce", gc.payload.lce_id, 4'h3);
    credit_pulse();

    // Stall raised mid-burst: remaining beat completes, next header waits.
    set_hdr(e_bedrock_req_uc_wr, 40'h80003000, e_bedrock_msg_size_16, 4'h1, 1'b1);
    send_hdr(hc, cap);
    send_beat(64'h1111_0000_1111_0000, 1'b0, dc, capd, capl);
    stall_i = 1'b1;
    mem_cmd_data_ready_and_i = 1'b0;
    fork
      send_beat(64'h2222_0000_2222_0000, 1'b1, dc2, capd, capl);
      begin
        @(posedge clk); #1;
        mem_cmd_data_ready_and_i = 1'b1;
      end
    join
    chk("stall_beat2_data", capd, 64'h2222_0000_2222_0000);
    chk("stall_beat2_last", capl, 1'b1);
    chk("stall_beat_order", dc2 > dc, 1'b1);
    set_hdr(e_bedrock_req_uc_rd, 40'h80004000, e_bedrock_msg_size_8, 4'h1, 1'b0);
    lce_req_header_v_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_hdr_held", lce_req_header_ready_and_o, 1'b0);
    end
    @(posedge clk); #1;
    stall_i = 1'b0;
    send_hdr(hc, cap);
    chk("stall_model_out", m_out, 2);
    credit_pulse();
    credit_pulse();
    @(negedge clk);
    chk("final_empty", empty_o, 1'b1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bp_cce_hybrid_uc_xlate.md
# bp_cce_hybrid_uc_xlate

Uncached-request translator for the hybrid CCE. It sits directly downstream of the request splitter's uncacheable output and consumes uncached LCE request bursts. It converts each burst into a BedRock memory command burst toward the memory/IO network. A credit counter bounds the number of outstanding memory commands, and the block drains cleanly for CCE mode changes.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies paddr, lce/cce id widths and assoc.
- `lce_data_width_p`, default `dword_width_gp`: request and command data width; identical on both sides, so there is no data gearing.
- `mem_credits_p`, default 4: maximum outstanding memory commands, ≥1.
- `clk_i`, input, 1: clock. Single clock domain.
- `reset_i`, input, 1: reset. Synchronous, active-high.
- `stall_i`, input, 1: blocks acceptance of new headers. An in-flight burst still completes.
- `empty_o`, output, 1: no burst in flight and all credits returned.
- `lce_req_header_i`, input, `lce_req_msg_header_width_lp`: uncached LCE request header.
- `lce_req_header_v_i`, input, 1: header valid.
- `lce_req_header_ready_and_o`, output, 1: header ready.
- `lce_req_has_data_i`, input, 1: a data beat train follows the header.
- `lce_req_data_i`, input, `lce_data_width_p`: request data beat.
- `lce_req_data_v_i`, input, 1: data valid.
- `lce_req_data_ready_and_o`, output, 1: data ready.
- `lce_req_last_i`, input, 1: final data beat.
- `mem_cmd_header_o`, output, `mem_fwd_header_width_lp`: memory command header.
- `mem_cmd_header_v_o`, output, 1: command header valid.
- `mem_cmd_header_ready_and_i`, input, 1: command header ready.
- `mem_cmd_has_data_o`, output, 1: the command carries data.
- `mem_cmd_data_o`, output, `lce_data_width_p`: command data beat.
- `mem_cmd_data_v_o`, output, 1: data valid.
- `mem_cmd_data_ready_and_i`, input, 1: data ready.
- `mem_cmd_last_o`, output, 1: final command data beat.
- `mem_credit_return_i`, input, 1: one memory response has completed.

## Operation
- FSM states:
  - `e_reset`: the only state occupied during reset.
  - `e_ready`: accepting headers.
  - `e_data`: forwarding beats.
- `e_reset` → `e_ready` on the first cycle after `reset_i` deasserts.
- Header forwarding in `e_ready`:
  - `mem_cmd_header_v_o` = `lce_req_header_v_i & ~stall_i & (credits != 0)`.
  - `lce_req_header_ready_and_o` = `mem_cmd_header_ready_and_i & ~stall_i & (credits != 0)`.
  - Both are 0 in every other state.
- Header handshake:
  - Always consumes one credit.
  - If `has_data`, go to `e_data`; otherwise stay in `e_ready`.
- Beat forwarding in `e_data`:
  - Data, valid and last pass through combinationally; each ready is wired to the opposite side's ready.
  - A handshake with `last` returns the FSM to `e_ready`.
  - Data valid and ready are forced to 0 outside `e_data`.
- Translation, field by field:
  - `e_bedrock_req_uc_rd` → `e_bedrock_mem_uc_rd`; `e_bedrock_req_uc_wr` → `e_bedrock_mem_uc_wr`.
  - `rd_miss` / `wr_miss` (cacheable request arriving in uncached-only mode) → `e_bedrock_mem_uc_rd`. Size is forced to the cache-block size.
  - `addr` and `size` copy through. `payload.lce_id` = request `src_id`. `payload.uncached` = 1. `way_id` and `state` are 0.
  - Any other type still forwards, as `uc_rd`. The sim-only assertion fires.
- Credit counter:
  - Width `$clog2(mem_credits_p+1)`; resets to `mem_credits_p`.
  - Decrements on header send and increments on `mem_credit_return_i`.
  - When both happen in the same cycle, the count is unchanged.
  - A return at full credits is an assertion error; the counter saturates.
- `empty_o` = `(state==e_ready) & (credits==mem_credits_p)`.

## Timing
- Zero-cycle latency for header and data; there are no internal buffers.
- Every output is a combinational function of state, credits and inputs.
- Reset values, while `reset_i` is high:
  - Every valid and every ready output is 0.
  - `empty_o` is 0.
  - Credits are `mem_credits_p`.
- The header and the first beat of a burst are never forwarded in the same cycle; the earliest first beat is one cycle after the header handshake.
- `stall_i` rising during `e_data` does not stop beats. It only blocks the next header.
- Credits reaching 0 block only headers. Data of the current burst continues.

## Structure
- The FSM state enum and the translation function (LCE req type → mem cmd type) go in `bp_me_pkg`.
- Header structs come from the existing bedrock LCE and mem macros.
- One natural sub-module: the credit counter as `bsg_counter_up_down`, with max value `mem_credits_p` and init value `mem_credits_p`.

## Test plan
- Reset, then one `uc_rd` at addr 0x8000_0040, size 8B:
  - `mem_cmd` carries type `uc_rd`, the same addr and size, and `uncached`=1.
  - Credits go 4→3; `empty_o` goes 0 until a credit returns.
- `uc_wr` with 1 beat of 0xDEAD_BEEF:
  - Header, then the beat with `last`=1, one cycle or more apart.
  - FSM back in `e_ready` after the beat.
- Five back-to-back `uc_rd`s with no credit returns:
  - Four forwarded; the fifth is held with `ready`=0.
  - One `mem_credit_return_i` releases it the next cycle.
- Header send and credit return in the same cycle: the count stays at 2.
- `rd_miss` (64B block) → `uc_rd`, size 64B.
- `stall_i` raised mid-burst (beat 1 of 2):
  - Beat 2 still completes.
  - The following header is held until `stall_i` drops.
  - `empty_o` goes 1 once all credits are returned.
